// File: rtl/cellrv32_package.sv
// Shared address map and helpers for the GPIO/interrupt block.
package cellrv32_package;

  localparam int unsigned gpio_width_c = 64;
  localparam int unsigned data_width_c = 32;

  localparam logic [31:0] gpio2_base_c = 32'hFFFF_FC00;
  localparam int unsigned gpio2_size_c = 64;

  localparam logic [31:0] gpio2_in_lo_c       = gpio2_base_c + 32'h00;
  localparam logic [31:0] gpio2_in_hi_c       = gpio2_base_c + 32'h04;
  localparam logic [31:0] gpio2_out_lo_c      = gpio2_base_c + 32'h08;
  localparam logic [31:0] gpio2_out_hi_c      = gpio2_base_c + 32'h0C;
  localparam logic [31:0] gpio2_oe_lo_c       = gpio2_base_c + 32'h10;
  localparam logic [31:0] gpio2_oe_hi_c       = gpio2_base_c + 32'h14;
  localparam logic [31:0] gpio2_irq_en_lo_c   = gpio2_base_c + 32'h18;
  localparam logic [31:0] gpio2_irq_en_hi_c   = gpio2_base_c + 32'h1C;
  localparam logic [31:0] gpio2_irq_pol_lo_c  = gpio2_base_c + 32'h20;
  localparam logic [31:0] gpio2_irq_pol_hi_c  = gpio2_base_c + 32'h24;
  localparam logic [31:0] gpio2_irq_pend_lo_c = gpio2_base_c + 32'h28;
  localparam logic [31:0] gpio2_irq_pend_hi_c = gpio2_base_c + 32'h2C;
  localparam logic [31:0] gpio2_out_set_lo_c  = gpio2_base_c + 32'h30;
  localparam logic [31:0] gpio2_out_set_hi_c  = gpio2_base_c + 32'h34;
  localparam logic [31:0] gpio2_out_clr_lo_c  = gpio2_base_c + 32'h38;
  localparam logic [31:0] gpio2_out_clr_hi_c  = gpio2_base_c + 32'h3C;

  // Bit mask with the lowest num bits set (num saturates at 64).
  function automatic logic [63:0] gpio_mask(input int unsigned num);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) begin
      m[i] = (32'(i) < num);
    end
    return m;
  endfunction

endpackage

// File: rtl/cellrv32_gpio_sync.sv
// Multi-stage input synchronizer with an extra previous-sample register for edge detection.
module cellrv32_gpio_sync #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[DEPTH-1];
    end
  end

  assign cur  = stage_q[DEPTH-1];
  assign prev = prev_q;

endmodule

// File: rtl/cellrv32_gpio_irq.sv
// 64-pin GPIO controller with per-pin edge interrupts, set/clear output aliases and a W1C pending register.
module cellrv32_gpio_irq
  import cellrv32_package::*;
#(
  parameter int unsigned GPIO_NUM    = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [31:0] addr_i,
  input  logic        rden_i,
  input  logic        wren_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  input  logic [63:0] gpio_i,
  output logic [63:0] gpio_o,
  output logic [63:0] gpio_oe_o,
  output logic        irq_o
);

  localparam int unsigned lo_c = $clog2(gpio2_size_c);
  localparam logic [63:0] mask_c = gpio_mask(GPIO_NUM);

  if (GPIO_NUM > 64) begin : g_bad_gpio_num
    $error("cellrv32_gpio_irq: GPIO_NUM must be in 0..64");
  end
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
    $error("cellrv32_gpio_irq: SYNC_STAGES must be in 2..4");
  end

  logic [63:0] out_q, oe_q, en_q, pol_q, pend_q;
  logic [63:0] out_nxt, oe_nxt, en_nxt, pol_nxt, clr_c;
  logic [63:0] sync_cur, sync_prev, in_c, edge_c;
  logic        sel_c, rd_c, wr_c;
  logic [3:0]  word_c;
  logic [31:0] rdata_c;
  logic        unused_addr;

  cellrv32_gpio_sync #(
    .WIDTH(gpio_width_c),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_i),
    .rstn_i(rstn_i),
    .din   (gpio_i),
    .cur   (sync_cur),
    .prev  (sync_prev)
  );

  assign sel_c       = (addr_i[31:lo_c] == gpio2_base_c[31:lo_c]);
  assign word_c      = addr_i[5:2];
  assign rd_c        = sel_c & rden_i;
  assign wr_c        = sel_c & wren_i;
  assign unused_addr = ^addr_i[1:0];
  assign in_c        = sync_cur & mask_c;

  // Edge only when the sample actually changed, so a polarity flip alone never fires.
  assign edge_c = ((pol_q & sync_cur & ~sync_prev) | (~pol_q & ~sync_cur & sync_prev)) & mask_c;

  // Register write decode.
  always_comb begin
    out_nxt = out_q;
    oe_nxt  = oe_q;
    en_nxt  = en_q;
    pol_nxt = pol_q;
    clr_c   = '0;
    if (wr_c) begin
      case (word_c)
        gpio2_out_lo_c[5:2]:      out_nxt[31:0]  = data_i;
        gpio2_out_hi_c[5:2]:      out_nxt[63:32] = data_i;
        gpio2_oe_lo_c[5:2]:       oe_nxt[31:0]   = data_i;
        gpio2_oe_hi_c[5:2]:       oe_nxt[63:32]  = data_i;
        gpio2_irq_en_lo_c[5:2]:   en_nxt[31:0]   = data_i;
        gpio2_irq_en_hi_c[5:2]:   en_nxt[63:32]  = data_i;
        gpio2_irq_pol_lo_c[5:2]:  pol_nxt[31:0]  = data_i;
        gpio2_irq_pol_hi_c[5:2]:  pol_nxt[63:32] = data_i;
        gpio2_irq_pend_lo_c[5:2]: clr_c[31:0]    = data_i;
        gpio2_irq_pend_hi_c[5:2]: clr_c[63:32]   = data_i;
        gpio2_out_set_lo_c[5:2]:  out_nxt[31:0]  = out_q[31:0] | data_i;
        gpio2_out_set_hi_c[5:2]:  out_nxt[63:32] = out_q[63:32] | data_i;
        gpio2_out_clr_lo_c[5:2]:  out_nxt[31:0]  = out_q[31:0] & ~data_i;
        gpio2_out_clr_hi_c[5:2]:  out_nxt[63:32] = out_q[63:32] & ~data_i;
        default: ;
      endcase
    end
  end

  // Read mux; set/clear aliases read back as zero.
  always_comb begin
    rdata_c = '0;
    case (word_c)
      gpio2_in_lo_c[5:2]:       rdata_c = in_c[31:0];
      gpio2_in_hi_c[5:2]:       rdata_c = in_c[63:32];
      gpio2_out_lo_c[5:2]:      rdata_c = out_q[31:0];
      gpio2_out_hi_c[5:2]:      rdata_c = out_q[63:32];
      gpio2_oe_lo_c[5:2]:       rdata_c = oe_q[31:0];
      gpio2_oe_hi_c[5:2]:       rdata_c = oe_q[63:32];
      gpio2_irq_en_lo_c[5:2]:   rdata_c = en_q[31:0];
      gpio2_irq_en_hi_c[5:2]:   rdata_c = en_q[63:32];
      gpio2_irq_pol_lo_c[5:2]:  rdata_c = pol_q[31:0];
      gpio2_irq_pol_hi_c[5:2]:  rdata_c = pol_q[63:32];
      gpio2_irq_pend_lo_c[5:2]: rdata_c = pend_q[31:0];
      gpio2_irq_pend_hi_c[5:2]: rdata_c = pend_q[63:32];
      default:                  rdata_c = '0;
    endcase
  end

  // New edges are OR-ed in after the clear, so a same-cycle set wins.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_q  <= '0;
      oe_q   <= '0;
      en_q   <= '0;
      pol_q  <= '0;
      pend_q <= '0;
      data_o <= '0;
      ack_o  <= 1'b0;
      irq_o  <= 1'b0;
    end else begin
      out_q  <= out_nxt & mask_c;
      oe_q   <= oe_nxt & mask_c;
      en_q   <= en_nxt & mask_c;
      pol_q  <= pol_nxt & mask_c;
      pend_q <= ((pend_q & ~clr_c) | (edge_c & en_q)) & mask_c;
      data_o <= rd_c ? rdata_c : 32'h0;
      ack_o  <= rd_c | wr_c;
      irq_o  <= |(pend_q & en_q);
    end
  end

  assign gpio_o    = out_q;
  assign gpio_oe_o = oe_q;

endmodule

// File: doc/cellrv32_gpio_irq.md
CELLRV32_GPIO_IRQ -- requirements
Module: cellrv32_gpio_irq

Interface
Parameters:
REQ-001 SHALL have parameter GPIO_NUM, default 64: number of implemented pins (0..64).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth (2..4).

Ports:
REQ-003 SHALL have port clk_i, input, 1: global clock, rising edge.
REQ-004 SHALL have port rstn_i, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port addr_i, input, 32: bus address.
REQ-006 SHALL have port rden_i, input, 1: read strobe, one cycle.
REQ-007 SHALL have port wren_i, input, 1: write strobe, one cycle.
REQ-008 SHALL have port data_i, input, 32: write data.
REQ-009 SHALL have port data_o, output, 32: read data.
REQ-010 SHALL have port ack_o, output, 1: transfer acknowledge.
REQ-011 SHALL have port gpio_i, input, 64: pin inputs.
REQ-012 SHALL have port gpio_o, output, 64: pin output values.
REQ-013 SHALL have port gpio_oe_o, output, 64: pin output enables, 1 = drive.
REQ-014 SHALL have port irq_o, output, 1: interrupt request, level, active-high.

Function
REQ-015 SHALL assert access enable when addr_i[hi:lo] equals gpio2_base_c[hi:lo] (lo = log2(gpio2_size_c)); the word index is addr_i[5:2].
REQ-016 SHALL implement this word map, each register as LO/HI pair (bits 31:0 / 63:32):
- 0x00/04 IN: RO, synchronized pins.
- 0x08/0C OUT: RW.
- 0x10/14 OE: RW.
- 0x18/1C IRQ_EN: RW.
- 0x20/24 IRQ_POL: RW; 1 = rising edge, 0 = falling edge.
- 0x28/2C IRQ_PEND: read; write-1-to-clear.
- 0x30/34 OUT_SET: WO; OUT |= data.
- 0x38/3C OUT_CLR: WO; OUT &= ~data.
REQ-017 SHALL assert ack_o exactly one cycle after any accepted rden_i or wren_i, including RO/WO targets; no ack when not selected.
REQ-018 SHALL register data_o one cycle after the read strobe; data_o SHALL be 0 in all other cycles and for WO words.
REQ-019 SHALL ignore writes to IN.
REQ-020 SHALL force bits >= GPIO_NUM of every register, gpio_o and gpio_oe_o to 0 (read 0, not writable).
REQ-021 SHALL pass gpio_i through a SYNC_STAGES-deep flop chain; IN reflects the last stage (latency SYNC_STAGES cycles).
REQ-022 SHALL keep one extra registered copy of the last sync stage; an edge is detected per pin from (prev, cur) according to IRQ_POL.
REQ-023 SHALL set IRQ_PEND[i] on a detected edge only while IRQ_EN[i] = 1; pending SHALL persist until W1C, even if IRQ_EN is later cleared.
REQ-024 SHALL give set priority on a W1C in the same cycle as a new edge on that pin: the bit stays 1.
REQ-025 SHALL register irq_o as OR(IRQ_PEND & IRQ_EN); one cycle after pend/en update.
REQ-026 SHALL not create a spurious edge when IRQ_POL changes.
REQ-027 SHALL drive gpio_o = OUT and gpio_oe_o = OE directly from registers.

Reset
REQ-028 SHALL asynchronously clear OUT, OE, IRQ_EN, IRQ_POL, IRQ_PEND, sync chain, previous-sample flop, data_o, ack_o and irq_o to 0 on rstn_i = 0.
REQ-029 SHALL drop an access in flight at reset with no ack after release.
REQ-030 SHALL detect no edge in the first cycle after reset, because the sync chain and previous-sample flop are both 0.

Structure
REQ-031 SHALL place gpio2_base_c, gpio2_size_c (64 bytes) and the 16 word-offset constants in cellrv32_package.
REQ-032 SHALL use one sub-module, cellrv32_gpio_sync (parametrised width/depth synchronizer with previous-sample output), instantiated once at 64 bits.
REQ-033 SHALL check GPIO_NUM in 0..64 and SYNC_STAGES in 2..4 with an initial assertion that reports an error.

Verification
REQ-034 SHALL cover: write OUT_LO = 0xA5A5A5A5, OE_LO = 0xFFFF0000 -> gpio_o[31:0] = 0xA5A5A5A5, gpio_oe_o[31:0] = 0xFFFF0000, ack one cycle later.
REQ-035 SHALL cover: OUT_LO = 0x0000000F, then OUT_SET_LO = 0xF0, then OUT_CLR_LO = 0x3 -> OUT_LO reads 0x000000FC.
REQ-036 SHALL cover: GPIO_NUM = 40, write 0xFFFFFFFF to OUT_HI -> reads 0x000000FF and gpio_o[63:40] = 0.
REQ-037 SHALL cover: IRQ_EN_LO bit 3 = 1, POL = 1, gpio_i[3] 0 -> 1 -> IRQ_PEND_LO = 0x8 after SYNC_STAGES+1 cycles, irq_o = 1 one cycle later; W1C 0x8 -> irq_o = 0.
REQ-038 SHALL cover: a W1C of pin 3 in the same cycle as a new rising edge on pin 3 -> pending stays 1 and irq_o stays 1.
REQ-039 SHALL cover: rstn_i pulsed low mid-read -> no ack, all outputs 0, and no interrupt while gpio_i is held at 1 after reset.
